mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/memwb_reg.sv | 51 +++++
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int REG_IDX_W  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic is_access(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: loads a full entry, or a bubble that clears the
// write-back controls while the data fields keep their last values.
module memwb_reg
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_bubble,
    input  logic [DW-1:0]        i_read_data,
    input  logic [DW-1:0]        i_alu_res,
    input  logic [DW-1:0]        i_pc1,
    input  logic [REG_IDX_W-1:0] i_wreg,
    input  logic                 i_reg_write,
    input  logic                 i_mem_to_reg,
    input  logic                 i_write_pc_4,
    output logic [DW-1:0]        o_read_data,
    output logic [DW-1:0]        o_alu_res,
    output logic [DW-1:0]        o_pc1,
    output logic [REG_IDX_W-1:0] o_wreg,
    output logic                 o_reg_write,
    output logic                 o_mem_to_reg,
    output logic                 o_write_pc_4
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_read_data  <= '0;
            o_alu_res    <= '0;
            o_pc1        <= '0;
            o_wreg       <= '0;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_write_pc_4 <= 1'b0;
        end else if (i_bubble) begin
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_write_pc_4 <= 1'b0;
        end else begin
            o_read_data  <= i_read_data;
            o_alu_res    <= i_alu_res;
            o_pc1        <= i_pc1;
            o_wreg       <= i_wreg;
            o_reg_write  <= i_reg_write;
            o_mem_to_reg <= i_mem_to_reg;
            o_write_pc_4 <= i_write_pc_4;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues one data-memory access per load/store, stalls the pipe
// until ack (or a timeout abort), and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        alu_res,
    input  logic [DW-1:0]        regb_data,
    input  logic [DW-1:0]        pc1,
    input  logic [REG_IDX_W-1:0] wreg,
    input  logic                 reg_write,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 mem_to_reg,
    input  logic                 write_pc_4,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DW-1:0]        dmem_addr,
    output logic [DW-1:0]        dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DW-1:0]        dmem_rdata,
    output logic                 stall,
    output logic                 err,
    output logic [DW-1:0]        wb_read_data,
    output logic [DW-1:0]        wb_alu_res,
    output logic [DW-1:0]        wb_pc1,
    output logic [REG_IDX_W-1:0] wb_wreg,
    output logic                 wb_reg_write,
    output logic                 wb_mem_to_reg,
    output logic                 wb_write_pc_4,
    output state_t               dbg_state
);

    localparam int             CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  C_MAX = CW'(TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_we;
    logic            r_err;
    logic            w_access;
    logic            w_timeout;
    logic            w_bubble;
    logic [DW-1:0]   w_rdata;

    assign w_access  = is_access(mem_read, mem_write);
    // Abort only when the final allowed cycle also sees no ack.
    assign w_timeout = (r_state == ACCESS) && !dmem_ack && (r_cnt == C_MAX);
    assign err       = r_err;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_access) w_next = ACCESS;
            ACCESS:  if (dmem_ack || w_timeout) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        w_bubble   = 1'b0;
        w_rdata    = '0;
        case (r_state)
            IDLE: begin
                stall    = w_access;
                w_bubble = w_access;
            end
            ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = r_we;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                stall      = !dmem_ack && !w_timeout;
                w_bubble   = !dmem_ack;
                w_rdata    = r_we ? '0 : dmem_rdata;
            end
            default: ;
        endcase
    end

    // Captured request; a simultaneous read+write is a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (r_state == IDLE && w_access) begin
            r_addr  <= alu_res;
            r_wdata <= regb_data;
            r_we    <= mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE || dmem_ack || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    memwb_reg #(.DW(DW)) u_memwb (
        .clk          (clk),
        .rst          (rst),
        .i_bubble     (w_bubble),
        .i_read_data  (w_rdata),
        .i_alu_res    (alu_res),
        .i_pc1        (pc1),
        .i_wreg       (wreg),
        .i_reg_write  (reg_write),
        .i_mem_to_reg (mem_to_reg),
        .i_write_pc_4 (write_pc_4),
        .o_read_data  (wb_read_data),
        .o_alu_res    (wb_alu_res),
        .o_pc1        (wb_pc1),
        .o_wreg       (wb_wreg),
        .o_reg_write  (wb_reg_write),
        .o_mem_to_reg (wb_mem_to_reg),
        .o_write_pc_4 (wb_write_pc_4)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a cycle-by-cycle vector table plus
// hand-written timeout and reset-during-access sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] alu_res, regb_data, pc1, dmem_rdata;
    logic [4:0]  wreg;
    logic        reg_write, mem_read, mem_write, mem_to_reg, write_pc_4, dmem_ack;
    logic        dmem_req, dmem_we, stall, err;
    logic [31:0] dmem_addr, dmem_wdata, wb_read_data, wb_alu_res, wb_pc1;
    logic [4:0]  wb_wreg;
    logic        wb_reg_write, wb_mem_to_reg, wb_write_pc_4;
    state_t      dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .alu_res(alu_res), .regb_data(regb_data), .pc1(pc1),
        .wreg(wreg), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .write_pc_4(write_pc_4), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .err(err),
        .wb_read_data(wb_read_data), .wb_alu_res(wb_alu_res), .wb_pc1(wb_pc1),
        .wb_wreg(wb_wreg), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_write_pc_4(wb_write_pc_4), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ctl = {reg_write, mem_read, mem_write, mem_to_reg, write_pc_4}
    // e_ctl = {wb_reg_write, wb_mem_to_reg, wb_write_pc_4} after the edge
    typedef struct {
        logic [31:0] alu;
        logic [31:0] regb;
        logic [31:0] pc;
        logic [4:0]  wr;
        logic [4:0]  ctl;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic [31:0] e_alu;
        logic [31:0] e_pc;
        logic [4:0]  e_wr;
        logic [2:0]  e_ctl;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_res    = v.alu;
        regb_data  = v.regb;
        pc1        = v.pc;
        wreg       = v.wr;
        {reg_write, mem_read, mem_write, mem_to_reg, write_pc_4} = v.ctl;
        dmem_ack   = v.ack;
        dmem_rdata = v.rdata;
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] pc, input logic [4:0] wr,
                          input logic [4:0] ctl, input logic ack, input logic [31:0] rd);
        alu_res    = a;
        regb_data  = 32'h0;
        pc1        = pc;
        wreg       = wr;
        {reg_write, mem_read, mem_write, mem_to_reg, write_pc_4} = ctl;
        dmem_ack   = ack;
        dmem_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ALU op, load, ack-in-IDLE, store with 3 waits, read+write, JAL-like, load
        vecs[0]  = '{32'h10, 32'h0, 32'h104, 5'd3, 5'b10000, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h10, 32'h104, 5'd3, 3'b100};
        vecs[1]  = '{32'h40, 32'h55, 32'h108, 5'd5, 5'b11010, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h10, 32'h104, 5'd3, 3'b000};
        vecs[2]  = '{32'h40, 32'h55, 32'h108, 5'd5, 5'b11010, 1'b1, 32'hDEADBEEF,
                     1'b0, 1'b1, 1'b0, 32'h40, 32'h55, 32'hDEADBEEF, 32'h40, 32'h108, 5'd5, 3'b110};
        vecs[3]  = '{32'h20, 32'h0, 32'h10C, 5'd7, 5'b00001, 1'b1, 32'hFFFFFFFF,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h20, 32'h10C, 5'd7, 3'b001};
        vecs[4]  = '{32'h80, 32'h1234, 32'h110, 5'd9, 5'b00100, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h20, 32'h10C, 5'd7, 3'b000};
        for (int i = 5; i < 8; i++)
            vecs[i] = '{32'h80, 32'h1234, 32'h110, 5'd9, 5'b00100, 1'b0, 32'hBAD0BAD0,
                        1'b1, 1'b1, 1'b1, 32'h80, 32'h1234, 32'h0, 32'h20, 32'h10C, 5'd7, 3'b000};
        vecs[8]  = '{32'h80, 32'h1234, 32'h110, 5'd9, 5'b00100, 1'b1, 32'hCAFE0000,
                     1'b0, 1'b1, 1'b1, 32'h80, 32'h1234, 32'h0, 32'h80, 32'h110, 5'd9, 3'b000};
        vecs[9]  = '{32'h90, 32'hA5A5, 32'h114, 5'd11, 5'b11110, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h80, 32'h110, 5'd9, 3'b000};
        vecs[10] = '{32'h90, 32'hA5A5, 32'h114, 5'd11, 5'b11110, 1'b1, 32'h77777777,
                     1'b0, 1'b1, 1'b1, 32'h90, 32'hA5A5, 32'h0, 32'h90, 32'h114, 5'd11, 3'b110};
        vecs[11] = '{32'h33, 32'h0, 32'h118, 5'd31, 5'b10001, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h33, 32'h118, 5'd31, 3'b101};
        vecs[12] = '{32'h44, 32'h66, 32'h11C, 5'd2, 5'b11010, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h33, 32'h118, 5'd31, 3'b000};
        vecs[13] = '{32'h44, 32'h66, 32'h11C, 5'd2, 5'b11010, 1'b1, 32'h0BADF00D,
                     1'b0, 1'b1, 1'b0, 32'h44, 32'h66, 32'h0BADF00D, 32'h44, 32'h11C, 5'd2, 3'b110};

        // Reset block
        rst = 1'b1;
        set_in(32'h0, 32'h0, 5'd0, 5'b00000, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wb_rd", wb_read_data, 32'h0);
        chk("rst_wb_alu", wb_alu_res, 32'h0);
        chk("rst_wb_pc1", wb_pc1, 32'h0);
        chk("rst_wb_ctl", 32'({wb_reg_write, wb_mem_to_reg, wb_write_pc_4, wb_wreg}), 32'h0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk("stall", 32'(stall), 32'(vecs[i].e_stall));
            chk("dmem_req", 32'(dmem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk("dmem_we", 32'(dmem_we), 32'(vecs[i].e_we));
                chk("dmem_addr", dmem_addr, vecs[i].e_addr);
                chk("dmem_wdata", dmem_wdata, vecs[i].e_wdata);
            end
            chk("err", 32'(err), 32'd0);
            next_cycle();
            chk("wb_read_data", wb_read_data, vecs[i].e_rd);
            chk("wb_alu_res", wb_alu_res, vecs[i].e_alu);
            chk("wb_pc1", wb_pc1, vecs[i].e_pc);
            chk("wb_wreg", 32'(wb_wreg), 32'(vecs[i].e_wr));
            chk("wb_ctl", 32'({wb_reg_write, wb_mem_to_reg, wb_write_pc_4}), 32'(vecs[i].e_ctl));
        end

        // Timeout: TIMEOUT=4, never ack -> abort in the 5th ACCESS cycle
        set_in(32'h200, 32'h180, 5'd6, 5'b11010, 1'b0, 32'h0);
        #1;
        chk("to_idle_stall", 32'(stall), 32'd1);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            chk("to_state", 32'(dbg_state), 32'(ACCESS));
            chk("to_req", 32'(dmem_req), 32'd1);
            chk("to_addr", dmem_addr, 32'h200);
            chk("to_stall", 32'(stall), (k < 4) ? 32'd1 : 32'd0);
            chk("to_err_pre", 32'(err), 32'd0);
            next_cycle();
        end
        chk("to_state_end", 32'(dbg_state), 32'(IDLE));
        chk("to_err", 32'(err), 32'd1);
        chk("to_bubble", 32'({wb_reg_write, wb_mem_to_reg, wb_write_pc_4}), 32'd0);
        chk("to_rd_hold", wb_read_data, 32'h0BADF00D);
        set_in(32'h24, 32'h184, 5'd8, 5'b10000, 1'b0, 32'h0);
        #1;
        chk("to_after_stall", 32'(stall), 32'd0);
        chk("to_after_req", 32'(dmem_req), 32'd0);
        next_cycle();
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_after_alu", wb_alu_res, 32'h24);
        chk("to_after_rw", 32'(wb_reg_write), 32'd1);
        next_cycle();
        chk("to_err_sticky2", 32'(err), 32'd1);

        // Reset pulse in the 2nd ACCESS cycle, ack arriving afterwards
        set_in(32'h300, 32'h200, 5'd4, 5'b11010, 1'b0, 32'h0);
        #1;
        chk("rs_stall", 32'(stall), 32'd1);
        next_cycle();
        chk("rs_req1", 32'(dmem_req), 32'd1);
        next_cycle();
        chk("rs_state2", 32'(dbg_state), 32'(ACCESS));
        rst = 1'b1;
        #1;
        chk("rs_req_drop", 32'(dmem_req), 32'd0);
        chk("rs_state", 32'(dbg_state), 32'(IDLE));
        chk("rs_err", 32'(err), 32'd0);
        chk("rs_wb_alu", wb_alu_res, 32'h0);
        chk("rs_wb_rd", wb_read_data, 32'h0);
        chk("rs_wb_pc1", wb_pc1, 32'h0);
        chk("rs_wb_ctl", 32'({wb_reg_write, wb_mem_to_reg, wb_write_pc_4, wb_wreg}), 32'h0);
        #1;
        rst = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        #1;
        chk("rs_ack_ign_req", 32'(dmem_req), 32'd0);
        next_cycle();
        chk("rs_ack_ign_rd", wb_read_data, 32'h0);
        chk("rs_ack_ign_rw", 32'(wb_reg_write), 32'd0);
        chk("rs_ack_ign_alu", wb_alu_res, 32'h0);
        chk("rs_reenter", 32'(dbg_state), 32'(ACCESS));
        chk("rs_addr", dmem_addr, 32'h300);
        next_cycle();
        chk("rs_done_rd", wb_read_data, 32'h12345678);
        chk("rs_done_alu", wb_alu_res, 32'h300);
        chk("rs_done_rw", 32'(wb_reg_write), 32'd1);
        chk("rs_done_state", 32'(dbg_state), 32'(IDLE));

        set_in(32'h0, 32'h0, 5'd0, 5'b00000, 1'b0, 32'h0);
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
